// File: rtl/ex_stage.sv
`timescale 1ns / 1ps
// Execute stage: ALU, HI/LO with single-cycle multiply and an iterative restoring divider,
// all feeding the EX/MEM pipeline register.
module ex_stage #(
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic               i_flush,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [4:0]         i_shamt,
  input  logic [4:0]         i_alu_op,
  input  logic               i_aluSrc,
  input  logic               i_link,
  input  logic [NB_DATA-1:0] i_pc8,
  input  logic [4:0]         i_reg2write,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic               i_mem2reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  output logic [NB_DATA-1:0] o_result,
  output logic [NB_DATA-1:0] o_data4Mem,
  output logic [4:0]         o_reg2write,
  output logic [1:0]         o_width,
  output logic               o_sign_flag,
  output logic               o_mem2reg,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_regWrite,
  output logic               o_stall_req,
  output logic               o_div_busy
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_MFHI  = 5'd16;
  localparam logic [4:0] OP_MFLO  = 5'd17;
  localparam logic [4:0] OP_MTHI  = 5'd18;
  localparam logic [4:0] OP_MTLO  = 5'd19;

  localparam int unsigned      CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  div_state_e r_state;
  div_state_e w_state_next;

  logic [NB_DATA-1:0]   w_op_b;
  logic [NB_DATA-1:0]   w_alu_res;
  logic [NB_DATA-1:0]   w_result;
  logic                 w_hilo_op;
  logic                 w_is_mult;
  logic                 w_is_div;
  logic                 w_is_signed_div;
  logic                 w_stall;
  logic                 w_accept;
  logic                 w_div_start;
  logic                 w_div_step;
  logic                 w_div_done;
  logic [2*NB_DATA-1:0] w_mul_a;
  logic [2*NB_DATA-1:0] w_mul_b;
  logic [2*NB_DATA-1:0] w_prod;
  logic [NB_DATA-1:0]   w_abs_a;
  logic [NB_DATA-1:0]   w_abs_b;
  logic [NB_DATA:0]     w_rem_shift;
  logic [NB_DATA:0]     w_rem_sub;
  logic                 w_q_bit;
  logic [NB_DATA-1:0]   w_rem_next;
  logic [NB_DATA-1:0]   w_quot_fix;
  logic [NB_DATA-1:0]   w_rem_fix;

  logic [NB_DATA-1:0]   r_hi;
  logic [NB_DATA-1:0]   r_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic [NB_DATA-1:0]   r_quot;
  logic [NB_DATA-1:0]   r_rem;
  logic [NB_DATA-1:0]   r_divisor;
  logic [NB_DATA-1:0]   r_dividend;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_div_zero;

  // ---------------------------------------------------------------------------------------------
  // Decode and hazard control
  // ---------------------------------------------------------------------------------------------
  assign w_op_b          = i_aluSrc ? i_imm : i_rt_data;
  assign w_hilo_op       = (i_alu_op >= OP_MULT) && (i_alu_op <= OP_MTLO);
  assign w_is_mult       = (i_alu_op == OP_MULT) || (i_alu_op == OP_MULTU);
  assign w_is_div        = (i_alu_op == OP_DIV) || (i_alu_op == OP_DIVU);
  assign w_is_signed_div = (i_alu_op == OP_DIV);

  assign w_stall     = o_div_busy && w_hilo_op;
  assign o_stall_req = w_stall;
  // Only an accepted instruction may touch HI/LO or start the divider.
  assign w_accept    = !i_halt && !i_flush && !w_stall;

  // ---------------------------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_alu_res = '0;
    case (i_alu_op)
      OP_ADD:  w_alu_res = i_rs_data + w_op_b;
      OP_SUB:  w_alu_res = i_rs_data - w_op_b;
      OP_AND:  w_alu_res = i_rs_data & w_op_b;
      OP_OR:   w_alu_res = i_rs_data | w_op_b;
      OP_XOR:  w_alu_res = i_rs_data ^ w_op_b;
      OP_NOR:  w_alu_res = ~(i_rs_data | w_op_b);
      OP_SLT:  w_alu_res = {{(NB_DATA-1){1'b0}}, $signed(i_rs_data) < $signed(w_op_b)};
      OP_SLTU: w_alu_res = {{(NB_DATA-1){1'b0}}, i_rs_data < w_op_b};
      OP_SLL:  w_alu_res = w_op_b << i_shamt;
      OP_SRL:  w_alu_res = w_op_b >> i_shamt;
      OP_SRA:  w_alu_res = $unsigned($signed(w_op_b) >>> i_shamt);
      OP_LUI:  w_alu_res = w_op_b << 16;
      OP_MFHI: w_alu_res = r_hi;
      OP_MFLO: w_alu_res = r_lo;
      default: w_alu_res = '0;
    endcase
  end

  assign w_result = i_link ? i_pc8 : w_alu_res;

  // Widen to 2*NB_DATA so one unsigned multiplier serves both signed and unsigned forms.
  assign w_mul_a = (i_alu_op == OP_MULT) ? {{NB_DATA{i_rs_data[NB_DATA-1]}}, i_rs_data}
                                         : {{NB_DATA{1'b0}}, i_rs_data};
  assign w_mul_b = (i_alu_op == OP_MULT) ? {{NB_DATA{w_op_b[NB_DATA-1]}}, w_op_b}
                                         : {{NB_DATA{1'b0}}, w_op_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // ---------------------------------------------------------------------------------------------
  // Divider FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else if (!i_halt) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_div_start) w_state_next = StBusy;
      StBusy:  if (r_cnt == LAST_CNT) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign o_div_busy  = (r_state != StIdle);
  assign w_div_start = (r_state == StIdle) && w_accept && w_is_div;

  always_comb begin
    w_div_step = 1'b0;
    w_div_done = 1'b0;
    unique case (r_state)
      StIdle:  ;
      StBusy:  w_div_step = 1'b1;
      StDone:  w_div_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Divider datapath: restoring division on magnitudes, sign fixed up on completion
  // ---------------------------------------------------------------------------------------------
  assign w_abs_a = (w_is_signed_div && i_rs_data[NB_DATA-1]) ? -i_rs_data : i_rs_data;
  assign w_abs_b = (w_is_signed_div && w_op_b[NB_DATA-1]) ? -w_op_b : w_op_b;

  assign w_rem_shift = {r_rem, r_quot[NB_DATA-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};
  assign w_q_bit     = !w_rem_sub[NB_DATA];
  assign w_rem_next  = w_q_bit ? w_rem_sub[NB_DATA-1:0] : w_rem_shift[NB_DATA-1:0];

  assign w_quot_fix = r_neg_q ? -r_quot : r_quot;
  assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (!i_halt) begin
      if (w_div_start) begin
        r_cnt      <= '0;
        r_quot     <= w_abs_a;
        r_rem      <= '0;
        r_divisor  <= w_abs_b;
        r_dividend <= i_rs_data;
        r_neg_q    <= w_is_signed_div && (i_rs_data[NB_DATA-1] ^ w_op_b[NB_DATA-1]);
        r_neg_r    <= w_is_signed_div && i_rs_data[NB_DATA-1];
        r_div_zero <= (w_op_b == '0);
      end else if (w_div_step) begin
        r_cnt  <= r_cnt + 1'b1;
        r_rem  <= w_rem_next;
        r_quot <= {r_quot[NB_DATA-2:0], w_q_bit};
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // HI / LO
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!i_halt) begin
      if (w_div_done) begin
        r_lo <= r_div_zero ? '1 : w_quot_fix;
        r_hi <= r_div_zero ? r_dividend : w_rem_fix;
      end else if (w_accept && w_is_mult) begin
        r_hi <= w_prod[2*NB_DATA-1:NB_DATA];
        r_lo <= w_prod[NB_DATA-1:0];
      end else if (w_accept && (i_alu_op == OP_MTHI)) begin
        r_hi <= i_rs_data;
      end else if (w_accept && (i_alu_op == OP_MTLO)) begin
        r_lo <= i_rs_data;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // EX/MEM register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result    <= '0;
      o_data4Mem  <= '0;
      o_reg2write <= '0;
      o_width     <= '0;
      o_sign_flag <= 1'b0;
      o_mem2reg   <= 1'b0;
      o_memRead   <= 1'b0;
      o_memWrite  <= 1'b0;
      o_regWrite  <= 1'b0;
    end else if (!i_halt) begin
      if (i_flush || w_stall) begin
        o_result    <= '0;
        o_data4Mem  <= '0;
        o_reg2write <= '0;
        o_width     <= '0;
        o_sign_flag <= 1'b0;
        o_mem2reg   <= 1'b0;
        o_memRead   <= 1'b0;
        o_memWrite  <= 1'b0;
        o_regWrite  <= 1'b0;
      end else begin
        o_result    <= w_result;
        o_data4Mem  <= i_rt_data;
        o_reg2write <= i_reg2write;
        o_width     <= i_width;
        o_sign_flag <= i_sign_flag;
        o_mem2reg   <= i_mem2reg;
        o_memRead   <= i_memRead;
        o_memWrite  <= i_memWrite;
        o_regWrite  <= i_regWrite;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns / 1ps
// Self-checking bench for ex_stage: expected EX/MEM contents are queued when an instruction is
// driven and compared one cycle later when the register presents them.
module tb_ex_stage;

  localparam int unsigned NB = 32;
  localparam int unsigned DC = 32;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_MFHI  = 5'd16;
  localparam logic [4:0] OP_MFLO  = 5'd17;
  localparam logic [4:0] OP_MTHI  = 5'd18;
  localparam logic [4:0] OP_MTLO  = 5'd19;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_halt;
  logic          i_flush;
  logic [NB-1:0] i_rs_data;
  logic [NB-1:0] i_rt_data;
  logic [NB-1:0] i_imm;
  logic [4:0]    i_shamt;
  logic [4:0]    i_alu_op;
  logic          i_aluSrc;
  logic          i_link;
  logic [NB-1:0] i_pc8;
  logic [4:0]    i_reg2write;
  logic [1:0]    i_width;
  logic          i_sign_flag;
  logic          i_mem2reg;
  logic          i_memRead;
  logic          i_memWrite;
  logic          i_regWrite;
  logic [NB-1:0] o_result;
  logic [NB-1:0] o_data4Mem;
  logic [4:0]    o_reg2write;
  logic [1:0]    o_width;
  logic          o_sign_flag;
  logic          o_mem2reg;
  logic          o_memRead;
  logic          o_memWrite;
  logic          o_regWrite;
  logic          o_stall_req;
  logic          o_div_busy;

  always #5 clk = ~clk;

  ex_stage #(
    .NB_DATA    (NB),
    .DIV_CYCLES (DC)
  ) u_dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_halt      (i_halt),
    .i_flush     (i_flush),
    .i_rs_data   (i_rs_data),
    .i_rt_data   (i_rt_data),
    .i_imm       (i_imm),
    .i_shamt     (i_shamt),
    .i_alu_op    (i_alu_op),
    .i_aluSrc    (i_aluSrc),
    .i_link      (i_link),
    .i_pc8       (i_pc8),
    .i_reg2write (i_reg2write),
    .i_width     (i_width),
    .i_sign_flag (i_sign_flag),
    .i_mem2reg   (i_mem2reg),
    .i_memRead   (i_memRead),
    .i_memWrite  (i_memWrite),
    .i_regWrite  (i_regWrite),
    .o_result    (o_result),
    .o_data4Mem  (o_data4Mem),
    .o_reg2write (o_reg2write),
    .o_width     (o_width),
    .o_sign_flag (o_sign_flag),
    .o_mem2reg   (o_mem2reg),
    .o_memRead   (o_memRead),
    .o_memWrite  (o_memWrite),
    .o_regWrite  (o_regWrite),
    .o_stall_req (o_stall_req),
    .o_div_busy  (o_div_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  string         exp_tag_q[$];
  logic [NB-1:0] exp_res_q[$];
  logic          exp_rw_q[$];

  // Architectural HI/LO as the bench expects them.
  logic [NB-1:0] m_hi;
  logic [NB-1:0] m_lo;

  typedef struct packed {
    logic [4:0]    op;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [4:0]    sh;
    logic [NB-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check_val(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [NB-1:0] res, input logic rw);
    exp_tag_q.push_back(tag);
    exp_res_q.push_back(res);
    exp_rw_q.push_back(rw);
  endtask

  task automatic tick();
    string         t;
    logic [NB-1:0] r;
    logic          w;
    @(posedge clk);
    #1;
    if (exp_res_q.size() > 0) begin
      t = exp_tag_q.pop_front();
      r = exp_res_q.pop_front();
      w = exp_rw_q.pop_front();
      check_val({t, "_res"}, o_result, r);
      check_val({t, "_rw"}, 32'(o_regWrite), 32'(w));
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [NB-1:0] rs, input logic [NB-1:0] rt,
                       input logic rw);
    i_alu_op    = op;
    i_rs_data   = rs;
    i_rt_data   = rt;
    i_regWrite  = rw;
    i_imm       = '0;
    i_aluSrc    = 1'b0;
    i_shamt     = '0;
    i_link      = 1'b0;
    i_pc8       = 32'h0000_0400;
    i_halt      = 1'b0;
    i_flush     = 1'b0;
    i_reg2write = 5'd9;
    i_width     = 2'd2;
    i_sign_flag = 1'b0;
    i_mem2reg   = 1'b0;
    i_memRead   = 1'b0;
    i_memWrite  = 1'b0;
  endtask

  task automatic div_model(input logic sgn, input logic [NB-1:0] a, input logic [NB-1:0] b);
    if (b == '0) begin
      m_lo = 32'hFFFF_FFFF;
      m_hi = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m_lo = 32'h8000_0000;
      m_hi = '0;
    end else if (sgn) begin
      m_lo = $signed(a) / $signed(b);
      m_hi = $signed(a) % $signed(b);
    end else begin
      m_lo = a / b;
      m_hi = a % b;
    end
  endtask

  // Issue a divide, then MFHI until it is accepted, then MFLO. Optionally slips an ADD in right
  // behind the divide, and optionally halts for halt_len cycles while the divider is busy.
  task automatic run_div(input string tag, input logic [4:0] op, input logic [NB-1:0] a,
                         input logic [NB-1:0] b, input bit add_first, input int halt_len);
    int stall_cycles;
    int k0;
    stall_cycles = int'(DC) + 1 + halt_len;
    drive(op, a, b, 1'b0);
    tick();
    div_model(op == OP_DIV, a, b);
    k0 = 0;
    if (add_first) begin
      drive(OP_ADD, 32'd40, 32'd2, 1'b1);
      #1;
      check_val({tag, "_add_stall"}, 32'(o_stall_req), 32'd0);
      check_val({tag, "_add_busy"}, 32'(o_div_busy), 32'd1);
      sb_push({tag, "_add"}, 32'd42, 1'b1);
      tick();
      k0 = 1;
    end
    for (int k = k0; k <= stall_cycles; k++) begin
      drive(OP_MFHI, '0, '0, 1'b1);
      i_halt  = (k >= 3) && (k < 3 + halt_len);
      i_flush = add_first && (k == 5);
      #1;
      check_val({tag, "_stall"}, 32'(o_stall_req), 32'(k < stall_cycles));
      if (k == k0) check_val({tag, "_busy"}, 32'(o_div_busy), 32'd1);
      if (k == stall_cycles) check_val({tag, "_idle"}, 32'(o_div_busy), 32'd0);
      if (k < stall_cycles) sb_push({tag, "_bubble"}, '0, 1'b0);
      else sb_push({tag, "_hi"}, m_hi, 1'b1);
      tick();
    end
    drive(OP_MFLO, '0, '0, 1'b1);
    sb_push({tag, "_lo"}, m_lo, 1'b1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000};
    vecs[1]  = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF};
    vecs[2]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000};
    vecs[3]  = '{OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0};
    vecs[4]  = '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0};
    vecs[5]  = '{OP_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F};
    vecs[6]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001};
    vecs[7]  = '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000};
    vecs[8]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000};
    vecs[9]  = '{OP_SLL,  32'h0000_0000, 32'h0000_00F1, 5'd4, 32'h0000_0F10};
    vecs[10] = '{OP_SRL,  32'h0000_0000, 32'h8000_0000, 5'd4, 32'h0800_0000};
    vecs[11] = '{OP_SRA,  32'h0000_0000, 32'h8000_0000, 5'd4, 32'hF800_0000};
    vecs[12] = '{OP_LUI,  32'h0000_0000, 32'h0000_1234, 5'd0, 32'h1234_0000};
    vecs[13] = '{5'd25,   32'h0000_0005, 32'h0000_0006, 5'd0, 32'h0000_0000};

    // Reset
    drive(OP_ADD, 32'd1, 32'd2, 1'b1);
    i_rst_n = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1;
    check_val("reset_res", o_result, '0);
    check_val("reset_rw", 32'(o_regWrite), 32'd0);
    check_val("reset_busy", 32'(o_div_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;

    // ALU table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      i_shamt = vecs[i].sh;
      sb_push($sformatf("alu%0d", i), vecs[i].exp, 1'b1);
      tick();
    end

    // Link override, immediate operand, store data
    drive(OP_SUB, 32'd1, 32'd2, 1'b1);
    i_link = 1'b1;
    sb_push("link", 32'h0000_0400, 1'b1);
    tick();
    drive(OP_ADD, 32'd10, 32'h999, 1'b1);
    i_aluSrc = 1'b1;
    i_imm    = 32'h20;
    sb_push("imm", 32'h2A, 1'b1);
    tick();
    check_val("data4mem", o_data4Mem, 32'h999);

    // Multiply
    drive(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    tick();
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFE;
    drive(OP_MFHI, '0, '0, 1'b1); sb_push("mult_hi", m_hi, 1'b1); tick();
    drive(OP_MFLO, '0, '0, 1'b1); sb_push("mult_lo", m_lo, 1'b1); tick();
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    tick();
    m_hi = 32'h0000_0001;
    m_lo = 32'hFFFF_FFFE;
    drive(OP_MFHI, '0, '0, 1'b1); sb_push("multu_hi", m_hi, 1'b1); tick();
    drive(OP_MFLO, '0, '0, 1'b1); sb_push("multu_lo", m_lo, 1'b1); tick();

    // MTHI/MTLO and flush suppression
    drive(OP_MTHI, 32'hCAFE_0001, '0, 1'b0); tick(); m_hi = 32'hCAFE_0001;
    drive(OP_MTLO, 32'hCAFE_0002, '0, 1'b0); tick(); m_lo = 32'hCAFE_0002;
    drive(OP_MULT, 32'd3, 32'd3, 1'b0);
    i_flush = 1'b1;
    sb_push("flush_mult", '0, 1'b0);
    tick();
    drive(OP_ADD, 32'd5, 32'd5, 1'b1);
    i_flush = 1'b1;
    sb_push("flush_add", '0, 1'b0);
    tick();
    drive(OP_MFHI, '0, '0, 1'b1); sb_push("mthi", m_hi, 1'b1); tick();
    drive(OP_MFLO, '0, '0, 1'b1); sb_push("mtlo", m_lo, 1'b1); tick();

    // Halt freezes EX/MEM
    drive(OP_ADD, 32'd1, 32'd2, 1'b1); sb_push("pre_halt", 32'd3, 1'b1); tick();
    drive(OP_SUB, 32'd9, 32'd1, 1'b1);
    i_halt = 1'b1;
    sb_push("halt_hold", 32'd3, 1'b1);
    tick();
    drive(OP_SUB, 32'd9, 32'd1, 1'b1); sb_push("post_halt", 32'd8, 1'b1); tick();

    // Divides
    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_div("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1'b0, 0);
    run_div("div_m9_0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 1'b0, 0);
    run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div("divu_halt", OP_DIVU, 32'd1000, 32'd7, 1'b0, 5);

    // Reset in the middle of a division
    drive(OP_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k == 9) begin
        drive(OP_ADD, 32'd1, 32'd2, 1'b1);
        sb_push("busy_add", 32'd3, 1'b1);
      end else begin
        drive(OP_MFHI, '0, '0, 1'b1);
        sb_push("rst_bubble", '0, 1'b0);
      end
      tick();
    end
    drive(OP_MFHI, '0, '0, 1'b1);
    i_rst_n = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1;
    check_val("midrst_busy", 32'(o_div_busy), 32'd0);
    check_val("midrst_res", o_result, '0);
    check_val("midrst_rw", 32'(o_regWrite), 32'd0);
    check_val("midrst_stall", 32'(o_stall_req), 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    sb_push("midrst_hi", m_hi, 1'b1);
    tick();
    drive(OP_MFLO, '0, '0, 1'b1); sb_push("midrst_lo", m_lo, 1'b1); tick();

    check_val("sb_drained", exp_res_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
